// File: rtl/led_scan_mux.sv
// ---------------------------------------------------------------------------
// led_scan_mux
//
// Time-multiplexed driver for a bank of LED digits sharing one segment bus.
// Each digit gets a slot of PRESCALE clocks. The first BLANK_CYCLES of a slot
// are blanked so the previous digit cannot ghost onto the next one. The rest
// of the slot drives the current digit, gated by its enable bit and by a PWM
// brightness comparator. Disabled digits are skipped by the scan.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   seg_in      digit d segment word at [d*SEG_W +: SEG_W], 1 = segment lit
//   digit_en    per-digit enable mask
//   bright      brightness, 0 = off, all-ones = full on
//   led_sel     one-hot digit select, active level set by SEL_ACTIVE_LOW
//   led_out     segment drive, inverted when SEG_ACTIVE_LOW = 1
//   frame_tick  one-cycle pulse when the scan wraps to a lower-or-equal digit
//
// All three outputs are registered and reflect the slot position one clock
// earlier. Reset forces them to their inactive levels without a clock edge.
// ---------------------------------------------------------------------------
module led_scan_mux #(
   parameter int NUM_DIGITS     = 4,
   parameter int SEG_W          = 8,
   parameter int PRESCALE       = 1000,
   parameter int BLANK_CYCLES   = 16,
   parameter int BRIGHT_W       = 4,
   parameter bit SEL_ACTIVE_LOW = 1'b1,
   parameter bit SEG_ACTIVE_LOW = 1'b0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_DIGITS*SEG_W-1:0] seg_in,
   input  logic [NUM_DIGITS-1:0]       digit_en,
   input  logic [BRIGHT_W-1:0]         bright,
   output logic [NUM_DIGITS-1:0]       led_sel,
   output logic [SEG_W-1:0]            led_out,
   output logic                        frame_tick
);

   localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CAND_W = IDX_W + 1;
   localparam int SLOT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   // Inactive output levels and frequently used constants
   localparam logic [NUM_DIGITS-1:0] SEL_IDLE    = {NUM_DIGITS{SEL_ACTIVE_LOW}};
   localparam logic [SEG_W-1:0]      SEG_IDLE    = {SEG_W{SEG_ACTIVE_LOW}};
   localparam logic [NUM_DIGITS-1:0] SEL_ONE     = NUM_DIGITS'(1'b1);
   localparam logic [SLOT_W-1:0]     SLOT_LAST   = SLOT_W'(PRESCALE - 1);
   localparam logic [SLOT_W-1:0]     BLANK_LAST  = SLOT_W'(BLANK_CYCLES - 1);
   localparam logic [SLOT_W-1:0]     SLOT_ZERO   = {SLOT_W{1'b0}};
   localparam logic [SLOT_W-1:0]     SLOT_ONE    = SLOT_W'(1'b1);
   localparam logic [BRIGHT_W-1:0]   BRIGHT_FULL = {BRIGHT_W{1'b1}};
   localparam logic [BRIGHT_W-1:0]   BRIGHT_ONE  = BRIGHT_W'(1'b1);
   localparam logic [CAND_W-1:0]     CAND_DIGITS = CAND_W'(NUM_DIGITS);

   // Elaboration-time guard on illegal parameter combinations
   generate
      if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_digits
         $error("led_scan_mux: NUM_DIGITS must be within 1..16");
      end
      if (BLANK_CYCLES < 1 || PRESCALE <= BLANK_CYCLES) begin : g_bad_timing
         $error("led_scan_mux: need 1 <= BLANK_CYCLES < PRESCALE");
      end
   endgenerate

   typedef enum logic [0:0] {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } state_t;

   // Registered state
   state_t                  state_r;
   logic [IDX_W-1:0]        idx_r;
   logic [SLOT_W-1:0]       slot_cnt_r;
   logic [BRIGHT_W-1:0]     pwm_cnt_r;
   logic [SEG_W-1:0]        seg_q_r;
   logic [NUM_DIGITS-1:0]   en_q_r;
   logic [BRIGHT_W-1:0]     bright_q_r;
   logic [NUM_DIGITS-1:0]   led_sel_r;
   logic [SEG_W-1:0]        led_out_r;
   logic                    frame_tick_r;

   // Combinational decisions
   state_t                  state_nxt_s;
   logic                    slot_start_s;
   logic                    slot_end_s;
   logic [CAND_W-1:0]       cand_s;
   logic [IDX_W-1:0]        next_idx_s;
   logic                    found_s;
   logic                    pwm_on_s;
   logic                    tick_s;
   logic [SEG_W-1:0]        seg_word_s;
   logic [NUM_DIGITS-1:0]   sel_s;
   logic [SEG_W-1:0]        out_s;

   assign slot_start_s = (slot_cnt_r == SLOT_ZERO);
   assign slot_end_s   = (slot_cnt_r == SLOT_LAST);
   assign seg_word_s   = seg_in[idx_r*SEG_W +: SEG_W];

   // Full brightness bypasses the comparator so all-ones means 100 % on
   assign pwm_on_s = (bright_q_r == BRIGHT_FULL) || (pwm_cnt_r < bright_q_r);

   // Search upward from idx (with wrap) for the next enabled digit using the
   // live enable mask; the last candidate tried is idx itself, so a lone
   // enabled digit keeps the scan parked on it. No enabled digit: hold idx.
   always_comb begin
      next_idx_s = idx_r;
      found_s    = 1'b0;
      cand_s     = {CAND_W{1'b0}};
      for (int k = 1; k <= NUM_DIGITS; k++) begin
         cand_s = {1'b0, idx_r} + CAND_W'(k);
         if (cand_s >= CAND_DIGITS) begin
            cand_s = cand_s - CAND_DIGITS;
         end else begin
            cand_s = cand_s;
         end
         if (!found_s && digit_en[cand_s[IDX_W-1:0]]) begin
            next_idx_s = cand_s[IDX_W-1:0];
            found_s    = 1'b1;
         end else begin
            next_idx_s = next_idx_s;
            found_s    = found_s;
         end
      end
   end

   // A frame ends when the scan wraps back to a lower-or-equal digit
   assign tick_s = slot_end_s && found_s && (next_idx_s <= idx_r);

   // Phase FSM next-state and the output decision for the following cycle
   always_comb begin
      state_nxt_s = state_r;
      sel_s       = SEL_IDLE;
      out_s       = SEG_IDLE;
      case (state_r)
         ST_BLANK: begin
            if (slot_cnt_r == BLANK_LAST) begin
               state_nxt_s = ST_DRIVE;
            end else begin
               state_nxt_s = ST_BLANK;
            end
         end
         ST_DRIVE: begin
            if (en_q_r[idx_r] && pwm_on_s) begin
               sel_s = SEL_IDLE ^ (SEL_ONE << idx_r);
               out_s = seg_q_r ^ SEG_IDLE;
            end else begin
               sel_s = SEL_IDLE;
               out_s = SEG_IDLE;
            end
            if (slot_end_s) begin
               state_nxt_s = ST_BLANK;
            end else begin
               state_nxt_s = ST_DRIVE;
            end
         end
         default: begin
            state_nxt_s = ST_BLANK;
            sel_s       = SEL_IDLE;
            out_s       = SEG_IDLE;
         end
      endcase
   end

   // Phase state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_BLANK;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Slot counter, digit index and free-running PWM counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_cnt_r <= SLOT_ZERO;
         idx_r      <= {IDX_W{1'b0}};
         pwm_cnt_r  <= {BRIGHT_W{1'b0}};
      end else begin
         pwm_cnt_r <= pwm_cnt_r + BRIGHT_ONE;
         if (slot_end_s) begin
            slot_cnt_r <= SLOT_ZERO;
            idx_r      <= next_idx_s;
         end else begin
            slot_cnt_r <= slot_cnt_r + SLOT_ONE;
         end
      end
   end

   // Per-slot snapshot of inputs so mid-slot changes cannot disturb the drive
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_q_r    <= {SEG_W{1'b0}};
         en_q_r     <= {NUM_DIGITS{1'b0}};
         bright_q_r <= {BRIGHT_W{1'b0}};
      end else if (slot_start_s) begin
         seg_q_r    <= seg_word_s;
         en_q_r     <= digit_en;
         bright_q_r <= bright;
      end
   end

   // Output registers, reset straight to the inactive levels
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_sel_r    <= SEL_IDLE;
         led_out_r    <= SEG_IDLE;
         frame_tick_r <= 1'b0;
      end else begin
         led_sel_r    <= sel_s;
         led_out_r    <= out_s;
         frame_tick_r <= tick_s;
      end
   end

   assign led_sel    = led_sel_r;
   assign led_out    = led_out_r;
   assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_led_scan_mux.sv
// ---------------------------------------------------------------------------
// Testbench for led_scan_mux (4 digits, 8-cycle slots, 2 blank cycles).
// A behavioural reference model predicts the outputs for every clock edge;
// predictions go into a queue as stimulus is applied and are popped and
// compared when the DUT outputs settle. A second instance with inverted
// segment polarity runs on the same stimulus.
// ---------------------------------------------------------------------------
module tb_led_scan_mux;

   localparam int P_PRE   = 8;
   localparam int P_BLANK = 2;

   typedef struct {
      logic [3:0] sel;
      logic [7:0] out;
      logic       tick;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] seg_in = 32'h0;
   logic [3:0]  digit_en = 4'h0;
   logic [3:0]  bright = 4'h0;
   logic [3:0]  led_sel;
   logic [7:0]  led_out;
   logic        frame_tick;
   logic [3:0]  led_sel_inv;
   logic [7:0]  led_out_inv;
   logic        frame_tick_inv;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int last_tick_cyc = 0;
   int last_period = 0;
   int tick_cnt = 0;
   int active_cnt = 0;
   bit saw_d3 = 1'b0;

   // reference model state
   int         m_idx;
   int         m_cnt;
   logic [3:0] m_pwm;
   logic [7:0] m_seg;
   logic [3:0] m_en;
   logic [3:0] m_bright;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   led_scan_mux #(
      .NUM_DIGITS(4), .SEG_W(8), .PRESCALE(P_PRE), .BLANK_CYCLES(P_BLANK),
      .BRIGHT_W(4), .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b0)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .digit_en(digit_en),
      .bright(bright), .led_sel(led_sel), .led_out(led_out),
      .frame_tick(frame_tick)
   );

   led_scan_mux #(
      .NUM_DIGITS(4), .SEG_W(8), .PRESCALE(P_PRE), .BLANK_CYCLES(P_BLANK),
      .BRIGHT_W(4), .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
   ) u_dut_inv (
      .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .digit_en(digit_en),
      .bright(bright), .led_sel(led_sel_inv), .led_out(led_out_inv),
      .frame_tick(frame_tick_inv)
   );

   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_idx = 0; m_cnt = 0; m_pwm = 4'h0;
      m_seg = 8'h00; m_en = 4'h0; m_bright = 4'h0;
      sb_q.delete();
   endtask

   // One clock: predict, advance model, let the DUT clock, then compare.
   task automatic step();
      exp_t e;
      bit   lit;
      bit   found;
      int   nidx;
      int   c;
      lit = (m_cnt >= P_BLANK) && m_en[m_idx] &&
            ((m_bright == 4'hF) || (m_pwm < m_bright));
      e.sel = lit ? ~(4'b0001 << m_idx) : 4'b1111;
      e.out = lit ? m_seg : 8'h00;
      nidx  = m_idx;
      found = 1'b0;
      for (int j = 1; j <= 4; j++) begin
         c = (m_idx + j) % 4;
         if (!found && digit_en[c]) begin
            nidx  = c;
            found = 1'b1;
         end
      end
      e.tick = (m_cnt == P_PRE - 1) && found && (nidx <= m_idx);
      sb_q.push_back(e);
      if (m_cnt == 0) begin
         m_seg    = seg_in[m_idx*8 +: 8];
         m_en     = digit_en;
         m_bright = bright;
      end
      if (m_cnt == P_PRE - 1) begin
         m_cnt = 0;
         m_idx = nidx;
      end else begin
         m_cnt = m_cnt + 1;
      end
      m_pwm = m_pwm + 4'd1;

      @(posedge clk);
      @(negedge clk);
      cyc++;
      e = sb_q.pop_front();
      check_val("led_sel", {28'h0, led_sel}, {28'h0, e.sel});
      check_val("led_out", {24'h0, led_out}, {24'h0, e.out});
      check_val("frame_tick", {31'h0, frame_tick}, {31'h0, e.tick});
      check_val("led_out_inv", {24'h0, led_out_inv}, {24'h0, ~e.out});
      check_val("led_sel_inv", {28'h0, led_sel_inv}, {28'h0, e.sel});
      check_val("sel_onehot", {31'h0, ($countones(~led_sel) <= 1)}, 32'h1);
      if (frame_tick) begin
         last_period   = cyc - last_tick_cyc;
         last_tick_cyc = cyc;
         tick_cnt++;
      end
      if (led_sel != 4'b1111) active_cnt++;
      if (led_sel == 4'b0111) saw_d3 = 1'b1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      check_val("rst_sel", {28'h0, led_sel}, 32'hF);
      check_val("rst_out", {24'h0, led_out}, 32'h00);
      check_val("rst_out_inv", {24'h0, led_out_inv}, 32'hFF);
      check_val("rst_tick", {31'h0, frame_tick}, 32'h0);

      // full scan, all digits, full brightness
      seg_in = 32'h44332211; digit_en = 4'b1111; bright = 4'hF;
      rst_n = 1'b1;
      run(96);
      check_val("period_1111", last_period, 32);

      // two alternating digits, then a single digit
      digit_en = 4'b0101;
      run(64);
      check_val("period_0101", last_period, 16);
      digit_en = 4'b0010;
      run(48);
      check_val("period_0010", last_period, 8);

      // nothing enabled: dark and no frame ticks
      digit_en = 4'b0000;
      run(16);
      tick_cnt = 0; active_cnt = 0;
      run(40);
      check_val("dis_ticks", tick_cnt, 0);
      check_val("dis_active", active_cnt, 0);
      digit_en = 4'b1000;
      run(16);
      check_val("dig3_seen", {31'h0, saw_d3}, 32'h1);

      // partial brightness, then zero brightness
      digit_en = 4'b1111; bright = 4'd4;
      run(64);
      bright = 4'd0;
      run(16);
      active_cnt = 0;
      run(800);
      check_val("bright0_active", active_cnt, 0);

      // segment word changed mid-slot
      bright = 4'hF;
      run(16);
      for (int i = 0; i < 16 && m_cnt != 4; i++) step();
      seg_in = 32'h88776655;
      run(40);

      // asynchronous reset in the middle of digit 2's drive phase
      for (int i = 0; i < 64 && !(m_idx == 2 && m_cnt == 5); i++) step();
      check_val("reach_d2s5", {31'h0, (m_idx == 2 && m_cnt == 5)}, 32'h1);
      check_val("pre_rst_sel", {28'h0, led_sel}, 32'hB);
      rst_n = 1'b0;
      #1;
      check_val("arst_sel", {28'h0, led_sel}, 32'hF);
      check_val("arst_out", {24'h0, led_out}, 32'h00);
      check_val("arst_out_inv", {24'h0, led_out_inv}, 32'hFF);
      check_val("arst_tick", {31'h0, frame_tick}, 32'h0);
      model_reset();
      repeat (3) @(negedge clk);
      check_val("hold_rst_sel", {28'h0, led_sel}, 32'hF);
      rst_n = 1'b1;
      run(40);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
